cus19_wb_ctrl: RTL and testbench

Write-back controller for the cus19 core: the producer side of the integer register-file write port.
- Accepts results from the ALU (8-bit) and the MUL/DIV unit (16-bit, pair result) over valid/ready handshakes.
- Arbitrates them onto the single write port, one write per cycle.
- Keeps a pending-destination scoreboard that decode uses for hazard stalls.
- Sits between execute units and the register file; the register file applies the low byte to rd and the high byte to rd+1 when wr_hi_en_out is set.

---
 rtl/cus19_pkg.sv | 19 +
 rtl/cus19_wb_ctrl_if.sv | 36 +++
 rtl/cus19_wb_scoreboard.sv | 27 ++
 rtl/cus19_wb_ctrl.sv | 90 +++++++++
 tb/tb_cus19_wb_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cus19_pkg.sv
// cus19_pkg: shared register-file widths, write-back source encoding and destination-mask helpers.
package cus19_pkg;
    localparam int DATA_WIDTH = 8;
    localparam int REG_ADDR_WIDTH = 4;
    localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;

    typedef enum logic [1:0] {WB_NONE, WB_ALU, WB_MD} wb_src_e;
    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [NUM_REGS-1:0] reg_mask_t;

    // rd+1 wraps naturally in the index width, so register 15 pairs with register 0
    function automatic reg_addr_t reg_inc(input reg_addr_t r);
        return r + reg_addr_t'(1);
    endfunction

    function automatic reg_mask_t reg_bits(input reg_addr_t r, input logic pair);
        return (reg_mask_t'(1) << r) | (pair ? reg_mask_t'(1) << reg_inc(r) : '0);
    endfunction
endpackage

// File: rtl/cus19_wb_ctrl_if.sv
// cus19_wb_ctrl_if: issue, execute-result and register-file write signals of the write-back controller.
interface cus19_wb_ctrl_if;
    import cus19_pkg::*;
    logic issue_valid_in;
    reg_addr_t issue_rd_in;
    logic issue_pair_in;
    reg_mask_t pend_mask_out;
    logic alu_valid_in;
    logic alu_ready_out;
    reg_addr_t alu_rd_in;
    logic [DATA_WIDTH-1:0] alu_data_in;
    logic md_valid_in;
    logic md_ready_out;
    reg_addr_t md_rd_in;
    logic [2*DATA_WIDTH-1:0] md_data_in;
    logic wr_en_out;
    logic wr_hi_en_out;
    reg_addr_t wr_addr_out;
    logic [2*DATA_WIDTH-1:0] wr_data_out;

    modport master (
        output issue_valid_in, issue_rd_in, issue_pair_in,
        output alu_valid_in, alu_rd_in, alu_data_in,
        output md_valid_in, md_rd_in, md_data_in,
        input pend_mask_out, alu_ready_out, md_ready_out,
        input wr_en_out, wr_hi_en_out, wr_addr_out, wr_data_out
    );

    modport slave (
        input issue_valid_in, issue_rd_in, issue_pair_in,
        input alu_valid_in, alu_rd_in, alu_data_in,
        input md_valid_in, md_rd_in, md_data_in,
        output pend_mask_out, alu_ready_out, md_ready_out,
        output wr_en_out, wr_hi_en_out, wr_addr_out, wr_data_out
    );
endinterface

// File: rtl/cus19_wb_scoreboard.sv
// cus19_wb_scoreboard: pending-destination mask; issue sets rd(/rd+1), the driven write clears them, set wins.
module cus19_wb_scoreboard import cus19_pkg::*; (
    input logic clk_in,
    input logic rst_in,
    input logic set_en_in,
    input reg_addr_t set_rd_in,
    input logic set_pair_in,
    input logic clr_en_in,
    input reg_addr_t clr_rd_in,
    input logic clr_pair_in,
    output reg_mask_t pend_mask_out
);
    reg_mask_t pend_q, pend_d, set_mask, clr_mask;

    always_comb begin
        set_mask = set_en_in ? reg_bits(set_rd_in, set_pair_in) : '0;
        clr_mask = clr_en_in ? reg_bits(clr_rd_in, clr_pair_in) : '0;
        pend_d = (pend_q & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) pend_q <= '0;
        else pend_q <= pend_d;
    end

    assign pend_mask_out = pend_q;
endmodule

// File: rtl/cus19_wb_ctrl.sv
// cus19_wb_ctrl: arbitrates held ALU and MUL/DIV results onto the single register-file write port.
module cus19_wb_ctrl import cus19_pkg::*; #(
    parameter int STARVE_LIMIT = 3
) (
    input logic clk_in,
    input logic rst_in,
    cus19_wb_ctrl_if.slave bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic alu_hv_q, alu_hv_d, md_hv_q, md_hv_d;
    reg_addr_t alu_rd_q, alu_rd_d, md_rd_q, md_rd_d;
    logic [DATA_WIDTH-1:0] alu_data_q, alu_data_d;
    logic [2*DATA_WIDTH-1:0] md_data_q, md_data_d;
    logic [SW-1:0] starve_q, starve_d;
    logic wr_en_q, wr_en_d, wr_hi_q, wr_hi_d;
    reg_addr_t wr_addr_q, wr_addr_d;
    logic [2*DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic alu_wins, alu_rdy, md_rdy, alu_acc, md_acc;
    wb_src_e grant;

    always_comb begin
        alu_wins = alu_hv_q && (!md_hv_q || starve_q == SW'(STARVE_LIMIT));
        grant = alu_wins ? WB_ALU : md_hv_q ? WB_MD : WB_NONE;
        // a hold register frees up in the same cycle its content is granted
        alu_rdy = rst_in && (!alu_hv_q || grant == WB_ALU);
        md_rdy = rst_in && (!md_hv_q || grant == WB_MD);
        alu_acc = bus.alu_valid_in && alu_rdy;
        md_acc = bus.md_valid_in && md_rdy;
        alu_hv_d = alu_acc || (alu_hv_q && grant != WB_ALU);
        md_hv_d = md_acc || (md_hv_q && grant != WB_MD);
        alu_rd_d = alu_acc ? bus.alu_rd_in : alu_rd_q;
        alu_data_d = alu_acc ? bus.alu_data_in : alu_data_q;
        md_rd_d = md_acc ? bus.md_rd_in : md_rd_q;
        md_data_d = md_acc ? bus.md_data_in : md_data_q;
        starve_d = grant == WB_ALU ? '0 : alu_hv_q ? starve_q + SW'(1) : starve_q;
        wr_en_d = grant != WB_NONE;
        wr_hi_d = grant == WB_MD;
        wr_addr_d = grant == WB_MD ? md_rd_q : grant == WB_ALU ? alu_rd_q : '0;
        wr_data_d = grant == WB_MD ? md_data_q : grant == WB_ALU ? {{DATA_WIDTH{1'b0}}, alu_data_q} : '0;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            alu_hv_q <= 1'b0;
            md_hv_q <= 1'b0;
            alu_rd_q <= '0;
            alu_data_q <= '0;
            md_rd_q <= '0;
            md_data_q <= '0;
            starve_q <= '0;
            wr_en_q <= 1'b0;
            wr_hi_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            alu_hv_q <= alu_hv_d;
            md_hv_q <= md_hv_d;
            alu_rd_q <= alu_rd_d;
            alu_data_q <= alu_data_d;
            md_rd_q <= md_rd_d;
            md_data_q <= md_data_d;
            starve_q <= starve_d;
            wr_en_q <= wr_en_d;
            wr_hi_q <= wr_hi_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.alu_ready_out = alu_rdy;
    assign bus.md_ready_out = md_rdy;
    assign bus.wr_en_out = wr_en_q;
    assign bus.wr_hi_en_out = wr_hi_q;
    assign bus.wr_addr_out = wr_addr_q;
    assign bus.wr_data_out = wr_data_q;

    // the write currently on the port retires its destination bits
    cus19_wb_scoreboard u_sb (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .set_en_in(bus.issue_valid_in),
        .set_rd_in(bus.issue_rd_in),
        .set_pair_in(bus.issue_pair_in),
        .clr_en_in(wr_en_q),
        .clr_rd_in(wr_addr_q),
        .clr_pair_in(wr_hi_q),
        .pend_mask_out(bus.pend_mask_out)
    );
endmodule

// File: tb/tb_cus19_wb_ctrl.sv
// tb_cus19_wb_ctrl: directed write-back scenarios against a behavioural model compared every cycle.
module tb_cus19_wb_ctrl;
    localparam int LIMIT = 3;

    typedef struct packed {
        logic [3:0] rd;
        logic [15:0] data;
    } res_t;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    int checks = 0;
    int errors = 0;
    res_t alu_q[$];
    res_t md_q[$];
    bit alu_acc_s = 0;
    bit md_acc_s = 0;

    // model: what each source holds, how often the ALU lost in a row, outstanding destinations, the write on the port now
    bit m_alu_full, m_md_full;
    res_t m_alu, m_md;
    int m_losses;
    bit [15:0] m_pend;
    bit e_en, e_hi;
    logic [3:0] e_addr;
    logic [15:0] e_data;

    cus19_wb_ctrl_if bus();

    cus19_wb_ctrl #(.STARVE_LIMIT(LIMIT)) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .bus(bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit [15:0] dest_bits(input logic [3:0] r, input bit pair);
        logic [3:0] nxt;
        nxt = r + 4'd1;
        dest_bits = 16'd1 << r;
        if (pair) dest_bits = dest_bits | (16'd1 << nxt);
    endfunction

    task automatic model_reset();
        m_alu_full = 0;
        m_md_full = 0;
        m_alu = '0;
        m_md = '0;
        m_losses = 0;
        m_pend = '0;
        e_en = 0;
        e_hi = 0;
        e_addr = '0;
        e_data = '0;
    endtask

    // compare the DUT with the model mid-cycle, then move the model on by one clock
    initial begin
        bit alu_take, md_take, exp_alu_rdy, exp_md_rdy, alu_stall, md_stall;
        bit [15:0] clr, set;
        logic [31:0] alu_prev, md_prev;
        alu_stall = 0;
        md_stall = 0;
        alu_prev = '0;
        md_prev = '0;
        model_reset();
        forever begin
            @(negedge clk_in);
            alu_acc_s = bus.alu_valid_in && bus.alu_ready_out;
            md_acc_s = bus.md_valid_in && bus.md_ready_out;
            if (!rst_in) model_reset();
            alu_take = m_alu_full && (!m_md_full || m_losses == LIMIT);
            md_take = m_md_full && !alu_take;
            exp_alu_rdy = rst_in && (!m_alu_full || alu_take);
            exp_md_rdy = rst_in && (!m_md_full || md_take);
            check("wr_en", bus.wr_en_out, e_en);
            check("wr_hi_en", bus.wr_hi_en_out, e_hi);
            check("wr_addr", bus.wr_addr_out, e_addr);
            check("wr_data", bus.wr_data_out, e_data);
            check("alu_ready", bus.alu_ready_out, exp_alu_rdy);
            check("md_ready", bus.md_ready_out, exp_md_rdy);
            check("pend_mask", bus.pend_mask_out, m_pend);
            if (rst_in && alu_stall) check("alu_stable", {bus.alu_valid_in, bus.alu_rd_in, bus.alu_data_in}, alu_prev);
            if (rst_in && md_stall) check("md_stable", {bus.md_valid_in, bus.md_rd_in, bus.md_data_in}, md_prev);
            alu_stall = rst_in && bus.alu_valid_in && !bus.alu_ready_out;
            md_stall = rst_in && bus.md_valid_in && !bus.md_ready_out;
            alu_prev = {bus.alu_valid_in, bus.alu_rd_in, bus.alu_data_in};
            md_prev = {bus.md_valid_in, bus.md_rd_in, bus.md_data_in};
            if (rst_in) begin
                clr = e_en ? dest_bits(e_addr, e_hi) : 16'd0;
                set = bus.issue_valid_in ? dest_bits(bus.issue_rd_in, bus.issue_pair_in) : 16'd0;
                if (bus.issue_valid_in) check("issue_protocol", (m_pend & ~clr & set) != 0, 0);
                m_pend = (m_pend & ~clr) | set;
                e_en = alu_take || md_take;
                e_hi = md_take;
                e_addr = alu_take ? m_alu.rd : md_take ? m_md.rd : 4'd0;
                e_data = alu_take ? m_alu.data : md_take ? m_md.data : 16'd0;
                if (alu_take) m_losses = 0;
                else if (m_alu_full) m_losses++;
                if (alu_take) m_alu_full = 0;
                if (md_take) m_md_full = 0;
                if (bus.alu_valid_in && exp_alu_rdy) begin
                    m_alu_full = 1;
                    m_alu = '{bus.alu_rd_in, {8'h00, bus.alu_data_in}};
                end
                if (bus.md_valid_in && exp_md_rdy) begin
                    m_md_full = 1;
                    m_md = '{bus.md_rd_in, bus.md_data_in};
                end
            end
        end
    end

    // each source presents the head of its queue until it is accepted
    initial begin
        bus.alu_valid_in = 0;
        bus.alu_rd_in = '0;
        bus.alu_data_in = '0;
        bus.md_valid_in = 0;
        bus.md_rd_in = '0;
        bus.md_data_in = '0;
        forever begin
            @(posedge clk_in);
            #2;
            if (alu_acc_s && alu_q.size() != 0) void'(alu_q.pop_front());
            if (md_acc_s && md_q.size() != 0) void'(md_q.pop_front());
            bus.alu_valid_in = alu_q.size() != 0;
            bus.md_valid_in = md_q.size() != 0;
            if (alu_q.size() != 0) begin
                bus.alu_rd_in = alu_q[0].rd;
                bus.alu_data_in = alu_q[0].data[7:0];
            end
            if (md_q.size() != 0) begin
                bus.md_rd_in = md_q[0].rd;
                bus.md_data_in = md_q[0].data;
            end
        end
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic issue(input logic [3:0] rd, input bit pair);
        bus.issue_valid_in = 1;
        bus.issue_rd_in = rd;
        bus.issue_pair_in = pair;
        step();
        bus.issue_valid_in = 0;
        bus.issue_pair_in = 0;
    endtask

    task automatic do_reset();
        rst_in = 0;
        step();
        step();
        rst_in = 1;
    endtask

    task automatic wait_acc(input bit md);
        bit ok;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk_in);
            ok = md ? (bus.md_valid_in && bus.md_ready_out) : (bus.alu_valid_in && bus.alu_ready_out);
        end
        check(md ? "md_accept_timeout" : "alu_accept_timeout", ok, 1);
    endtask

    initial begin
        logic [15:0] t4_exp [11] = '{16'h1000, 16'h1001, 16'h1002, 16'h00A0, 16'h1003, 16'h1004,
                                     16'h1005, 16'h00A1, 16'h1006, 16'h1007, 16'h00A2};
        logic [15:0] t4_seq [16];
        logic [7:0] hi_pat;
        int n, stalls;
        bus.issue_valid_in = 0;
        bus.issue_rd_in = '0;
        bus.issue_pair_in = 0;
        repeat (2) @(negedge clk_in);
        check("reset_wr_en", bus.wr_en_out, 0);
        check("reset_pend", bus.pend_mask_out, 0);
        check("reset_md_ready", bus.md_ready_out, 0);
        step();
        rst_in = 1;
        step();
        // held md result is dropped by a reset before its write
        issue(4'd3, 1);
        md_q.push_back('{4'd3, 16'hBEEF});
        wait_acc(1);
        step();
        rst_in = 0;
        step();
        step();
        rst_in = 1;
        n = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_in);
            if (bus.wr_en_out) n++;
        end
        check("t1_no_write", n, 0);
        check("t1_pend", bus.pend_mask_out, 0);
        check("t1_md_ready", bus.md_ready_out, 1);
        step();
        // single ALU result reaches the port two cycles after acceptance
        issue(4'd5, 0);
        alu_q.push_back('{4'd5, 16'h003C});
        wait_acc(0);
        repeat (2) @(negedge clk_in);
        check("t2_wr_en", bus.wr_en_out, 1);
        check("t2_wr_hi", bus.wr_hi_en_out, 0);
        check("t2_wr_addr", bus.wr_addr_out, 5);
        check("t2_wr_data", bus.wr_data_out, 16'h003C);
        check("t2_pend_during", bus.pend_mask_out[5], 1);
        @(negedge clk_in);
        check("t2_pend_after", bus.pend_mask_out[5], 0);
        step();
        // pair write at rd=15 wraps to register 0
        issue(4'd15, 1);
        @(negedge clk_in);
        check("t3_pend_set", bus.pend_mask_out, 16'h8001);
        md_q.push_back('{4'd15, 16'h1234});
        wait_acc(1);
        repeat (2) @(negedge clk_in);
        check("t3_wr_addr", bus.wr_addr_out, 15);
        check("t3_wr_hi", bus.wr_hi_en_out, 1);
        check("t3_wr_data", bus.wr_data_out, 16'h1234);
        @(negedge clk_in);
        check("t3_pend_clear", bus.pend_mask_out, 0);
        step();
        // re-issue of rd=7 in the cycle its write retires keeps the bit
        issue(4'd7, 0);
        alu_q.push_back('{4'd7, 16'h0055});
        wait_acc(0);
        step();
        step();
        bus.issue_valid_in = 1;
        bus.issue_rd_in = 4'd7;
        @(negedge clk_in);
        check("t5_write_rd7", {bus.wr_en_out, bus.wr_addr_out}, {1'b1, 4'd7});
        step();
        bus.issue_valid_in = 0;
        @(negedge clk_in);
        check("t5_pend_kept", bus.pend_mask_out[7], 1);
        alu_q.push_back('{4'd7, 16'h0066});
        wait_acc(0);
        repeat (3) @(negedge clk_in);
        check("t5_pend_retired", bus.pend_mask_out, 0);
        step();
        // both sources streaming: three md grants, then one starved ALU grant
        do_reset();
        for (int i = 0; i < 8; i++) md_q.push_back('{4'(i), 16'h1000 + 16'(i)});
        for (int i = 0; i < 3; i++) alu_q.push_back('{4'(8 + i), 16'h00A0 + 16'(i)});
        n = 0;
        hi_pat = '0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk_in);
            if (bus.wr_en_out) begin
                if (n < 16) t4_seq[n] = bus.wr_data_out;
                if (n < 8) hi_pat = {hi_pat[6:0], bus.wr_hi_en_out};
                n++;
            end
        end
        check("t4_write_count", n, 11);
        check("t4_hi_pattern", hi_pat, 8'b11101110);
        for (int i = 0; i < 11; i++) check("t4_order", t4_seq[i], t4_exp[i]);
        step();
        // ALU result waits behind a continuous md stream until the starve limit
        do_reset();
        alu_q.push_back('{4'd1, 16'h0011});
        alu_q.push_back('{4'd2, 16'h0022});
        for (int i = 0; i < 12; i++) md_q.push_back('{4'd9, 16'h2000 + 16'(i)});
        stalls = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_in);
            if (bus.alu_valid_in && !bus.alu_ready_out) stalls++;
        end
        check("t6_alu_stalls", stalls, LIMIT);
        check("t6_drained", alu_q.size() + md_q.size(), 0);
        repeat (3) @(negedge clk_in);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
